// File: rtl/mux_arb_pkg.sv
// ============================================================================
//  Module      : mux_arb_pkg
//  Description : Shared types and helpers for the 4-to-1 round-robin mux
//                arbiter: FSM state encoding, requester count, select width,
//                and an index-to-one-hot helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  // Turns a requester index into its one-hot grant vector.
  function automatic logic [NUM_REQ-1:0] idx2onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational rotate-priority encoder. Returns the first set
//                request bit scanning ptr_i, ptr_i+1, ... (mod 4).
//                Optional macro PRIO0_EN adds prio0_i: when high, a set
//                req_i[0] wins regardless of the rotation pointer.
//  Ports       : req_i  [3:0] request vector
//                ptr_i  [1:0] rotation start index
//                prio0_i      (PRIO0_EN only) source 0 urgent
//                idx_o  [1:0] chosen index (meaningful when any_o)
//                any_o        at least one request set
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [SEL_W-1:0]   ptr_i,
`ifdef PRIO0_EN
  input  logic               prio0_i,
`endif
  output logic [SEL_W-1:0]   idx_o,
  output logic               any_o
);

  logic [SEL_W-1:0] w_cand;

  always_comb begin
    idx_o  = ptr_i;
    any_o  = |req_i;
    w_cand = ptr_i;
    // Scan from the farthest candidate back to ptr_i so the nearest set
    // request (in rotation order) is the last one written.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_cand = ptr_i + SEL_W'(k);
      if (req_i[w_cand]) begin
        idx_o = w_cand;
      end
    end
`ifdef PRIO0_EN
    if (prio0_i && req_i[0]) begin
      idx_o = '0;
    end
`endif
  end

endmodule

`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
// ============================================================================
//  Module      : mux4_rr_arbiter
//  Description : Round-robin scheduler sharing one 4-to-1 mux channel among
//                four requesters, with a per-owner burst limit. Registers the
//                selected data bit onto y_o, qualified by valid_o.
//                Optional macro PRIO0_EN: source 0 wins every arbitration
//                point (never preempts an ongoing burst).
//  Ports       : clk_i        clock, rising edge
//                rst_i        asynchronous active-high reset
//                req_i  [3:0] requests
//                d0_i..d3_i   data bit per source
//                gnt_o  [3:0] registered one-hot grant, zero when idle
//                s0_o, s1_o   registered mux select, {s1,s0} = owner
//                y_o          registered selected data bit
//                valid_o      y_o carries owner data
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int BURST_MAX = 4,
  parameter int CNT_W     = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               d0_i,
  input  logic               d1_i,
  input  logic               d2_i,
  input  logic               d3_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               s0_o,
  output logic               s1_o,
  output logic               y_o,
  output logic               valid_o
);

  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     owner_q, owner_d;
  logic [SEL_W-1:0]     ptr_q,   ptr_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic [NUM_REQ-1:0]   gnt_q,   gnt_d;
  logic                 y_q,     y_d;
  logic                 valid_q, valid_d;

  logic [NUM_REQ-1:0]   w_d;
  logic [SEL_W-1:0]     w_pick_ptr;
  logic [SEL_W-1:0]     w_pick_idx;
  logic                 w_pick_any;
  logic                 w_owner_req;
  logic                 w_release;

  assign w_d         = {d3_i, d2_i, d1_i, d0_i};
  assign w_owner_req = req_i[owner_q];
  assign w_release   = !w_owner_req || (cnt_q == BURST_LIM);

  // While owning, the only use of the picker is at release, where the scan
  // must start at the pointer the release is about to write (owner+1).
  assign w_pick_ptr  = (state_q == ST_OWN) ? owner_q + SEL_W'(1) : ptr_q;

  rr_pick u_pick (
    .req_i   (req_i),
    .ptr_i   (w_pick_ptr),
`ifdef PRIO0_EN
    .prio0_i (1'b1),
`endif
    .idx_o   (w_pick_idx),
    .any_o   (w_pick_any)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    y_d     = 1'b0;
    valid_d = 1'b0;

    if (state_q == ST_IDLE) begin
      if (w_pick_any) begin
        state_d = ST_OWN;
        owner_d = w_pick_idx;
        gnt_d   = idx2onehot(w_pick_idx);
        cnt_d   = CNT_W'(1);
      end
    end else begin
      // Data is only captured while the owner still requests; an owner that
      // drops its request gets no sample at the edge it is released.
      if (w_owner_req) begin
        y_d     = w_d[owner_q];
        valid_d = 1'b1;
      end
      if (w_release) begin
        ptr_d = owner_q + SEL_W'(1);
        if (w_pick_any) begin
          owner_d = w_pick_idx;
          gnt_d   = idx2onehot(w_pick_idx);
          cnt_d   = CNT_W'(1);
        end else begin
          // Select lines keep the last owner while idle.
          state_d = ST_IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      y_q     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign gnt_o      = gnt_q;
  assign {s1_o, s0_o} = owner_q;
  assign y_o        = y_q;
  assign valid_o    = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
// ============================================================================
//  Module      : tb_mux4_rr_arbiter
//  Description : Self-checking bench for mux4_rr_arbiter. A behavioural model
//                tracks owner / hold time / pointer as integers and predicts
//                every output each cycle; literal checks pin the model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux4_rr_arbiter;

  localparam int BURST = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] d;
  logic [3:0] gnt;
  logic       s0, s1, y, valid;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.BURST_MAX(BURST), .CNT_W(3)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_i   (req),
    .d0_i    (d[0]),
    .d1_i    (d[1]),
    .d2_i    (d[2]),
    .d3_i    (d[3]),
    .gnt_o   (gnt),
    .s0_o    (s0),
    .s1_o    (s1),
    .y_o     (y),
    .valid_o (valid)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model state: owner -1 means idle.
  int m_owner, m_sel, m_ptr, m_held;
  bit m_y, m_valid;

  function automatic int pick(input logic [3:0] r, input int start);
`ifdef PRIO0_EN
    if (r[0]) return 0;
`endif
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_sel = 0; m_ptr = 0; m_held = 0; m_y = 0; m_valid = 0;
  endtask

  task automatic model_edge(input logic [3:0] r, input logic [3:0] dv);
    int p;
    bit ny, nv;
    ny = 0; nv = 0;
    if (m_owner < 0) begin
      p = pick(r, m_ptr);
      if (p >= 0) begin m_owner = p; m_sel = p; m_held = 1; end
    end else begin
      if (r[m_owner]) begin nv = 1; ny = dv[m_owner]; end
      if (!r[m_owner] || m_held == BURST) begin
        m_ptr = (m_owner + 1) % 4;
        p = pick(r, m_ptr);
        if (p >= 0) begin m_owner = p; m_sel = p; m_held = 1; end
        else begin m_owner = -1; m_held = 0; end
      end else begin
        m_held++;
      end
    end
    m_y = ny; m_valid = nv;
  endtask

  function automatic logic [7:0] model_vec();
    logic [3:0] g;
    logic [1:0] s;
    g = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    s = 2'(m_sel);
    return {g, s, m_y, m_valid};
  endfunction

  function automatic logic [7:0] dut_vec();
    return {gnt, s1, s0, y, valid};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got {gnt,s1,s0,y,valid}=%b, expected %b", name, $time, act, exp);
    end
  endtask

  // One clock edge: model follows the same inputs, then outputs are compared.
  task automatic step();
    @(posedge clk);
    model_edge(req, d);
    #1;
    check("cycle", dut_vec(), model_vec());
  endtask

  // Async reset pulse placed between edges; outputs must clear without a clock.
  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("async_rst", dut_vec(), 8'h00);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [3:0] e;
    rst = 1'b1;
    req = 4'b1111;
    d   = 4'b0000;
    model_reset();

    // 1. Reset with everything requesting, then idle with no requests.
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", dut_vec(), 8'h00);
    #2 rst = 1'b0;
    req = 4'b0000;
    repeat (3) step();
    check("idle_no_req", dut_vec(), 8'h00);

    // 2. Single request from source 2 with D2=1.
    req = 4'b0100; d = 4'b0100;
    step();
    check("t2_grant", dut_vec(), {4'b0100, 2'b10, 1'b0, 1'b0});
    step();
    check("t2_data", dut_vec(), {4'b0100, 2'b10, 1'b1, 1'b1});
    req = 4'b0000;
    step();
    check("t2_idle", dut_vec(), {4'b0000, 2'b10, 1'b0, 1'b0});

    // 3. All requesting: four cycles per owner, no idle gaps.
    pulse_reset();
    req = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      d = 4'($urandom);
      step();
      e = 4'b0001 << (i / 4);
      check("t3_rotation", {4'b0000, gnt}, {4'b0000, e});
    end
    step();
    check("t3_wrap", {4'b0000, gnt}, 8'b0000_0001);

    // 4. Owner 1 drops after two cycles with 0 and 3 pending -> owner 3.
    pulse_reset();
    req = 4'b0010;
    step();
    step();
    req = 4'b1001;
    step();
    check("t4_next_owner", {4'b0000, gnt}, 8'b0000_1000);
    req = 4'b0000;
    step();
    check("t4_idle", {4'b0000, gnt}, 8'h00);

    // 5. Lone requester across several burst expiries.
    req = 4'b0010;
    step();
    for (int i = 0; i < 10; i++) begin
      d = 4'($urandom);
      step();
      check("t5_hold", {3'b000, gnt, valid}, {3'b000, 4'b0010, 1'b1});
    end

    // 6. Owner 2 completes its burst before source 0 is served; then reset
    //    mid-burst and restart from pointer 0.
    pulse_reset();
    req = 4'b0100;
    step();
    step();
    req = 4'b0101;
    step();
    check("t6_no_preempt", {4'b0000, gnt}, 8'b0000_0100);
    step();
    check("t6_no_preempt", {4'b0000, gnt}, 8'b0000_0100);
    step();
    check("t6_src0", {4'b0000, gnt}, 8'b0000_0001);
    step();
    pulse_reset();
    req = 4'b1111;
    step();
    check("t6_restart", {4'b0000, gnt}, 8'b0000_0001);

    // 7. Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) != 0) req = 4'($urandom);
      d = 4'($urandom);
      if ($urandom_range(0, 59) == 0) pulse_reset();
      else step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
